ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Parametrised iterative RV32M/RV64M multiply/divide unit sitting beside the EX-stage ALU.
//  Accepts one op per start and raises a stall request while it iterates.
//  Returns a registered result with a one-cycle done pulse, which the EX stage muxes into rd_data.
//  Handles all signed/unsigned variants, divide-by-zero, signed overflow and pipeline purge.
// PARAMETERS
//  XLEN      32  operand/result width (32 or 64)
//  CNT_W     $clog2(XLEN)+1  iteration counter width (localparam, derived, not overridable)
// PORTS
//  clk          in   1     clock
//  rst_n        in   1     reset, asynchronous, active-low
//  rst_pipe     in   1     synchronous pipeline clear, same effect as reset
//  start_i      in   1     EX holds a valid M-ext op (already qualified by ~jmp_purge_ma)
//  op_i         in   3     funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//  rs1_i        in   XLEN  forwarded operand 1
//  rs2_i        in   XLEN  forwarded operand 2
//  kill_i       in   1     purge: abandon the current op
//  stall_req_o  out  1     stall request to the pipeline stall logic
//  done_o       out  1     one-cycle pulse: result_o valid this cycle
//  result_o     out  XLEN  result, held until the next accepted start
// BEHAVIOUR
//  Reset / rst_pipe: state=IDLE; done_o=0; result_o=0; counter=0; accumulators=0.
//  States: IDLE, MUL, DIV, FIX, DONE.
//  Accept: start_i & (IDLE|DONE) & ~kill_i. Operands and op are latched, so later changes to rs*_i are don't-care.
//  Operand prep at accept:
//   - Signed ops take the absolute value of the operands.
//   - Result-sign and remainder-sign flags are latched.
//   - MULHSU treats only rs1 as signed.
//  MUL: radix-2 shift-add, one bit per cycle, 2*XLEN product, XLEN cycles, then FIX.
//  DIV: restoring divide, one quotient bit per cycle, XLEN cycles, then FIX.
//  FIX (1 cycle):
//   - Two's-complement negate where the sign flag requires it.
//   - Select the output: MUL low half; MULH* high half; DIV/DIVU quotient; REM/REMU remainder.
//   - Load result_o, go to DONE.
//  DONE (1 cycle): done_o=1. Next state is IDLE, or a new op if start_i is set (back-to-back allowed).
//  Latency, start cycle to done_o: XLEN+2 cycles (34 at XLEN=32).
//  Special cases are detected at accept, skip iteration, go straight to DONE; done_o one cycle after start:
//   - divisor==0: DIV/DIVU quotient=all ones; REM/REMU=rs1.
//   - signed overflow (rs1=MIN, rs2=-1): DIV quotient=MIN; REM=0.
//  stall_req_o = (start_i & IDLE & ~kill_i) | MUL | DIV | FIX. It is 0 in DONE, so the pipeline advances on the done cycle.
//   - Combinational from start_i, so the first cycle stalls without delay.
//   - Not asserted for a special-case op's start cycle, since DONE follows next cycle.
//  kill_i in MUL/DIV/FIX: go to IDLE next cycle, no done_o, result_o unchanged.
//  kill_i in DONE: done_o still pulses (already committed); no new op is accepted.
//  start_i while MUL/DIV/FIX: ignored, since the EX stage is stalled and holds the same op.
//  Counter counts down from XLEN-1; the exit to FIX happens on count==0. No wrap.
// CONFIGURATION
//  EX_MULDIV_FAST_MUL_EN defined:
//   - MUL* ops use a single-cycle combinational XLEN x XLEN multiply.
//   - Path is IDLE->FIX->DONE; done_o 2 cycles after start.
//   - DIV path unchanged.
//  Not defined: iterative multiply, XLEN+2 cycles, minimum area.
// STRUCTURE
//  Shared package muldiv_pkg:
//   - funct3 localparams OP_MUL..OP_REMU.
//   - State encoding ST_IDLE..ST_DONE (3 bits).
//   - XLEN-dependent MIN-value constant function.
//  One sub-module: muldiv_div_step, combinational single restoring iteration:
//   - Inputs: partial remainder, dividend bit, divisor.
//   - Outputs: next remainder, quotient bit.
//  Everything else, including the multiply step, stays inline.
// TESTING
//  1. MULH rs1=0xFFFFFFFF (-1), rs2=0x00000002 -> result 0xFFFFFFFF; done_o exactly 34 cycles after start.
//  2. DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
//  3. DIVU rs1=0x1234, rs2=0 -> 0xFFFFFFFF; REMU -> 0x1234; done_o 1 cycle after start; stall_req_o never high.
//  4. DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000; REM -> 0; special-case path taken.
//  5. MUL 3x5 started, kill_i at cycle 10 -> IDLE next cycle, no done_o, result_o keeps the prior value.
//     Then MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
//  6. Back-to-back: REMU 100%7 with start_i held into DONE by the next DIVU 100/7 -> results 2 then 14.
//     Second done_o lands 34 cycles after the first.
//     Repeat with the fast-multiply macro defined: MUL 3x5=15, done_o at 2 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: funct3 codes, FSM encoding
// and the XLEN-dependent most-negative-value helper.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Most negative two's-complement value of an xlen-bit word, zero-extended to 64 bits.
  function automatic logic [63:0] min_val(input int unsigned xlen);
    min_val = 64'd1 << (xlen - 1);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor if it fits.
module muldiv_div_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic         q_o
);

  logic [W:0] trial;

  // rem_i < divisor, so {rem_i, bit_i} fits in W+1 bits and trial[W] is a clean borrow flag.
  always_comb begin
    trial = {rem_i, bit_i} - {1'b0, divisor_i};
    q_o   = ~trial[W];
    rem_o = q_o ? trial[W-1:0] : {rem_i[W-2:0], bit_i};
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit beside the EX-stage ALU.
// Define EX_MULDIV_FAST_MUL_EN for a single-cycle combinational multiplier (DIV stays iterative).
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rst_pipe,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            stall_req_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MinVal = XLEN'(min_val(XLEN));

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                done_q, done_d;

  // Operand preparation at accept
  logic            sgn1, sgn2, s1, s2, neg_in, is_rem;
  logic            div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] abs1, abs2, special_res;

  always_comb begin
    sgn1 = (op_i == OP_MULH) | (op_i == OP_MULHSU) | (op_i == OP_DIV) | (op_i == OP_REM);
    sgn2 = (op_i == OP_MULH) | (op_i == OP_DIV) | (op_i == OP_REM);
    s1   = sgn1 & rs1_i[XLEN-1];
    s2   = sgn2 & rs2_i[XLEN-1];
    abs1 = s1 ? -rs1_i : rs1_i;
    abs2 = s2 ? -rs2_i : rs2_i;
    case (op_i)
      OP_MULH, OP_DIV:   neg_in = s1 ^ s2;
      OP_MULHSU, OP_REM: neg_in = s1;
      default:           neg_in = 1'b0;
    endcase
    is_rem   = op_i[2] & op_i[1];
    div_zero = op_i[2] & (rs2_i == '0);
    div_ovf  = ((op_i == OP_DIV) | (op_i == OP_REM)) & (rs1_i == MinVal) & (rs2_i == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = is_rem ? rs1_i : '1;
    else          special_res = is_rem ? '0 : MinVal;
    accept = start_i & ((state_q == ST_IDLE) | (state_q == ST_DONE)) & ~kill_i;
  end

  assign stall_req_o = (start_i & (state_q == ST_IDLE) & ~kill_i & ~special) |
                       (state_q == ST_MUL) | (state_q == ST_DIV) | (state_q == ST_FIX);

`ifdef EX_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
  assign fast_prod = {{XLEN{1'b0}}, abs1} * {{XLEN{1'b0}}, abs2};
`else
  // Shift-add step: acc = {partial product, remaining multiplier bits}
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
  end
`endif

  // Divide step: acc = {partial remainder, dividend bits shifting out / quotient bits in}
  logic [XLEN-1:0]   div_rem;
  logic              div_q;
  logic [2*XLEN-1:0] div_next;

  muldiv_div_step #(
    .W(XLEN)
  ) u_div_step (
    .rem_i    (acc_q[2*XLEN-1:XLEN]),
    .bit_i    (acc_q[XLEN-1]),
    .divisor_i(mcand_q),
    .rem_o    (div_rem),
    .q_o      (div_q)
  );

  assign div_next = {div_rem, acc_q[XLEN-2:0], div_q};

  // Sign fix-up and output selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot, rem, fix_res;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot     = acc_q[XLEN-1:0];
    rem      = acc_q[2*XLEN-1:XLEN];
    case (op_q)
      OP_MUL:                      fix_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             fix_res = neg_q ? -quot : quot;
      default:                     fix_res = neg_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (accept) begin
      op_d  = op_i;
      neg_d = neg_in;
      if (special) begin
        result_d = special_res;
        done_d   = 1'b1;
        state_d  = ST_DONE;
      end else if (!op_i[2]) begin
`ifdef EX_MULDIV_FAST_MUL_EN
        acc_d   = fast_prod;
        state_d = ST_FIX;
`else
        acc_d   = {{XLEN{1'b0}}, abs1};
        mcand_d = abs2;
        cnt_d   = CNT_W'(XLEN - 1);
        state_d = ST_MUL;
`endif
      end else begin
        acc_d   = {{XLEN{1'b0}}, abs1};
        mcand_d = abs2;
        cnt_d   = CNT_W'(XLEN - 1);
        state_d = ST_DIV;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_MUL: begin
          if (kill_i) begin
            state_d = ST_IDLE;
          end else begin
`ifndef EX_MULDIV_FAST_MUL_EN
            acc_d = mul_next;
`endif
            if (cnt_q == '0) state_d = ST_FIX;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        ST_DIV: begin
          if (kill_i) begin
            state_d = ST_IDLE;
          end else begin
            acc_d = div_next;
            if (cnt_q == '0) state_d = ST_FIX;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (kill_i) begin
            state_d = ST_IDLE;
          end else begin
            result_d = fix_res;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (rst_pipe) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (XLEN=32) with hand-computed results.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

`ifdef EX_MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = 34;
`endif

  logic        clk = 1'b0;
  logic        rst_n, rst_pipe, start_i, kill_i;
  logic [2:0]  op_i;
  logic [31:0] rs1_i, rs2_i;
  logic        stall_req_o, done_o;
  logic [31:0] result_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(
    .XLEN(32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rst_pipe   (rst_pipe),
    .start_i    (start_i),
    .op_i       (op_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .kill_i     (kill_i),
    .stall_req_o(stall_req_o),
    .done_o     (done_o),
    .result_o   (result_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op for a single cycle, then scramble the operand inputs and wait for done_o.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                       input bit exp_stall);
    int n;
    bit st;
    op_i    = op;
    rs1_i   = a;
    rs2_i   = b;
    start_i = 1'b1;
    #1;
    check({tag, "_stall_start"}, 64'(stall_req_o), 64'(exp_stall));
    @(posedge clk); #1;
    n  = 1;
    st = done_o ? 1'b0 : stall_req_o;
    start_i = 1'b0;
    rs1_i   = $urandom;
    rs2_i   = $urandom;
    op_i    = 3'($urandom);
    while (!done_o && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (!done_o) st |= stall_req_o;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, 64'(result_o), 64'(exp_res));
    check({tag, "_stall_busy"}, 64'(st), 64'(exp_stall));
    check({tag, "_stall_done"}, 64'(stall_req_o), 64'(0));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done_o), 64'(0));
  endtask

  initial begin
    int  n;
    bit  seen;
    rst_n    = 1'b0;
    rst_pipe = 1'b0;
    start_i  = 1'b0;
    kill_i   = 1'b0;
    op_i     = '0;
    rs1_i    = '0;
    rs2_i    = '0;
    #1;
    check("reset_done", 64'(done_o), 64'(0));
    check("reset_result", 64'(result_o), 64'(0));
    check("reset_stall", 64'(stall_req_o), 64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("mulh_neg", OP_MULH, 32'hFFFF_FFFF, 32'h2, MulLat, 32'hFFFF_FFFF, 1'b1);
    do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'h2, 34, 32'hFFFF_FFFD, 1'b1);
    do_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'h2, 34, 32'hFFFF_FFFF, 1'b1);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1'b0);
    do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 1'b0);
    do_op("divu_zero", OP_DIVU, 32'h1234, 32'h0, 1, 32'hFFFF_FFFF, 1'b0);
    do_op("remu_zero", OP_REMU, 32'h1234, 32'h0, 1, 32'h1234, 1'b0);

`ifndef EX_MULDIV_FAST_MUL_EN
    // Kill a MUL mid-iteration: no done_o, result_o keeps the REMU value.
    op_i    = OP_MUL;
    rs1_i   = 32'd3;
    rs2_i   = 32'd5;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (8) @(posedge clk);
    #1 kill_i = 1'b1;
    @(posedge clk); #1;
    kill_i = 1'b0;
    check("kill_stall", 64'(stall_req_o), 64'(0));
    check("kill_done", 64'(done_o), 64'(0));
    check("kill_result", 64'(result_o), 64'(32'h1234));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= done_o;
    end
    check("kill_no_done", 64'(seen), 64'(0));
`endif

    do_op("mulhu_max", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat, 32'hFFFF_FFFE, 1'b1);
    do_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MulLat, 32'hFFFF_FFFF, 1'b1);
    do_op("mul_lo_neg", OP_MUL, 32'hFFFF_FFFD, 32'd5, MulLat, 32'hFFFF_FFF1, 1'b1);
    do_op("mul_3x5", OP_MUL, 32'd3, 32'd5, MulLat, 32'd15, 1'b1);
    do_op("div_negdiv", OP_DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 1'b1);
    do_op("rem_negdiv", OP_REM, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 1'b1);
    do_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd2, 34, 32'h7FFF_FFFF, 1'b1);

    // Back-to-back: start_i held through REMU, next op presented on the done cycle.
    op_i    = OP_REMU;
    rs1_i   = 32'd100;
    rs2_i   = 32'd7;
    start_i = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done_o && n < 200);
    check("b2b_remu_latency", 64'(n), 64'(34));
    check("b2b_remu_result", 64'(result_o), 64'(2));
    op_i = OP_DIVU;
    #1;
    check("b2b_stall_in_done", 64'(stall_req_o), 64'(0));
    @(posedge clk); #1;
    start_i = 1'b0;
    n = 1;
    check("b2b_gap_done", 64'(done_o), 64'(0));
    while (!done_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_divu_latency", 64'(n), 64'(34));
    check("b2b_divu_result", 64'(result_o), 64'(14));
    @(posedge clk); #1;

    // Synchronous pipeline clear mid-divide behaves like reset.
    op_i    = OP_DIVU;
    rs1_i   = 32'd100;
    rs2_i   = 32'd7;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_pipe = 1'b1;
    @(posedge clk); #1;
    rst_pipe = 1'b0;
    check("rst_pipe_result", 64'(result_o), 64'(0));
    check("rst_pipe_stall", 64'(stall_req_o), 64'(0));
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= done_o;
    end
    check("rst_pipe_no_done", 64'(seen), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
